// File: rtl/piece_bag_queue.sv
// piece_bag_queue
// Tetromino source for the game core. A free-running 16-bit Galois LFSR
// picks shapes from a "bag" so that every shape is dealt exactly once per
// bag. A short FIFO holds the head piece plus a preview window. Spawn logic
// pops the head with next_req while piece_valid is high. seed_load restarts
// the sequence, which makes games reproducible.

module piece_bag_queue #(
  parameter int          NUM_SHAPES    = 7,
  parameter int          PREVIEW_DEPTH = 3,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       seed_load,
  input  logic [15:0]                seed_in,
  input  logic                       next_req,
  output logic                       piece_valid,
  output logic [2:0]                 piece_shape,
  output logic [1:0]                 piece_rot,
  output logic [3*PREVIEW_DEPTH-1:0] preview_shapes,
  output logic                       preview_valid,
  output logic [2:0]                 queue_count,
  output logic [3:0]                 bag_remaining
);

  // The queue holds the head slot plus the preview slots.
  localparam int                    DEPTH     = PREVIEW_DEPTH + 1;
  localparam logic [2:0]            DEPTH_C   = 3'(DEPTH);
  localparam logic [3:0]            NUM_C     = 4'(NUM_SHAPES);
  localparam logic [15:0]           LFSR_TAPS = 16'hB400;
  localparam logic [NUM_SHAPES-1:0] BAG_FULL  = '1;

  // The occupancy state is a pure function of count: FILL while slots are
  // free, FULL when every slot is occupied.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [15:0]           lfsr;
  logic [15:0]           lfsr_next;
  logic [15:0]           seed_value;
  logic [NUM_SHAPES-1:0] bag_mask;
  logic [NUM_SHAPES-1:0] bag_after_pick;
  logic [7:0]            pick_onehot;
  logic [2:0]            pick_shape;
  logic [1:0]            pick_rot;
  logic [2:0]            count;
  logic [2:0]            occ_after_pop;
  logic                  do_pop;
  logic                  do_push;
  logic [0:0]            state;
  logic [2:0]            slot_shape [DEPTH];
  logic [1:0]            slot_rot   [DEPTH];

  // Right-shifting Galois LFSR for x^16+x^14+x^13+x^11+1. A non-zero state
  // never reaches zero. A zero seed is replaced by SEED.
  assign lfsr_next  = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  assign seed_value = (seed_in == 16'h0000) ? SEED : seed_in;

  // LFSR register: free-runs every cycle; seed_load restarts it.
  // NOTE: sequential state uses non-blocking assignment, so every register
  // samples pre-edge values and the block order cannot change the behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= SEED;
    end else if (seed_load) begin
      lfsr <= seed_value;
    end else begin
      lfsr <= lfsr_next;
    end
  end

  // Pick the first undealt shape at or after the LFSR-derived start index.
  // The scan wraps to index 0. The bag is never empty, so a shape is always
  // found.
  // NOTE: every variable gets a default at the top of a combinational block,
  // so no path leaves one unassigned and no latch is inferred.
  always_comb begin : pick_comb
    logic [3:0] start;
    logic [3:0] idx;
    logic [7:0] mask8;
    logic       found;
    mask8      = 8'(bag_mask);
    start      = {1'b0, lfsr[2:0]};
    idx        = '0;
    found      = 1'b0;
    pick_shape = '0;
    if (start >= NUM_C) start = start - NUM_C;
    for (int k = 0; k < NUM_SHAPES; k++) begin
      idx = start + 4'(k);
      if (idx >= NUM_C) idx = idx - NUM_C;
      if (!found && mask8[idx[2:0]]) begin
        found      = 1'b1;
        pick_shape = idx[2:0];
      end
    end
  end

  assign pick_rot       = lfsr[4:3];
  assign pick_onehot    = 8'b1 << pick_shape;
  assign bag_after_pick = bag_mask & ~pick_onehot[NUM_SHAPES-1:0];

  // A pop needs a head entry. A push happens whenever a slot is free after
  // the pop, so a full queue that is popped refills in the same cycle.
  assign do_pop        = next_req && (count != 3'd0);
  assign occ_after_pop = count - {2'b00, do_pop};
  assign do_push       = (occ_after_pop < DEPTH_C);

  // Bag mask: clear the dealt shape. Reload to a full bag on the same edge
  // that deals the last shape.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bag_mask <= BAG_FULL;
    end else if (seed_load) begin
      bag_mask <= BAG_FULL;
    end else if (do_push) begin
      bag_mask <= (bag_after_pick == '0) ? BAG_FULL : bag_after_pick;
    end
  end

  // Occupancy count: a push and a pop in the same cycle cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 3'd0;
    end else if (seed_load) begin
      count <= 3'd0;
    end else begin
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  // Slot storage: shift toward the head on a pop, then write the new piece
  // at the tail that remains after the pop.
  // NOTE: storage has no reset. Outputs are gated by count, so stale slot
  // contents never reach a port.
  always_ff @(posedge clk) begin
    if (!seed_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_pop && (i < DEPTH - 1)) begin
          slot_shape[i] <= slot_shape[(i < DEPTH - 1) ? i + 1 : i];
          slot_rot[i]   <= slot_rot[(i < DEPTH - 1) ? i + 1 : i];
        end
        if (do_push && (occ_after_pop == 3'(i))) begin
          slot_shape[i] <= pick_shape;
          slot_rot[i]   <= pick_rot;
        end
      end
    end
  end

  // Occupancy state derived from count.
  assign state = (count == DEPTH_C) ? ST_FULL : ST_FILL;

  // Head outputs are forced to zero while the queue is empty.
  assign piece_valid   = (count != 3'd0);
  assign piece_shape   = piece_valid ? slot_shape[0] : 3'd0;
  assign piece_rot     = piece_valid ? slot_rot[0] : 2'd0;
  assign preview_valid = (state == ST_FULL);
  assign queue_count   = count;

  // Preview window: entry i shows queue slot i+1, or zero when that slot is
  // empty.
  always_comb begin
    preview_shapes = '0;
    for (int i = 0; i < PREVIEW_DEPTH; i++) begin
      if (count > 3'(i + 1)) preview_shapes[3*i +: 3] = slot_shape[i + 1];
    end
  end

  // Count the shapes not yet dealt from the current bag.
  always_comb begin
    bag_remaining = 4'd0;
    for (int i = 0; i < NUM_SHAPES; i++) begin
      bag_remaining = bag_remaining + {3'b000, bag_mask[i]};
    end
  end

endmodule

// File: tb/tb_piece_bag_queue.sv
// Testbench for piece_bag_queue. Two builds (7/3 and 4/6) share the stimulus
// and are compared cycle by cycle against a queue-based reference model.
`timescale 1ns/1ps

module tb_piece_bag_queue;

  localparam logic [15:0] TB_SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        reset, seed_load, next_req;
  logic [15:0] seed_in;

  always #5 clk = ~clk;

  logic       a_valid, a_pvalid;
  logic [2:0] a_shape, a_count;
  logic [1:0] a_rot;
  logic [8:0] a_prev;
  logic [3:0] a_rem;

  logic        b_valid, b_pvalid;
  logic [2:0]  b_shape, b_count;
  logic [1:0]  b_rot;
  logic [17:0] b_prev;
  logic [3:0]  b_rem;

  piece_bag_queue #(.NUM_SHAPES(7), .PREVIEW_DEPTH(3), .SEED(TB_SEED)) dut_a (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .next_req(next_req), .piece_valid(a_valid), .piece_shape(a_shape),
    .piece_rot(a_rot), .preview_shapes(a_prev), .preview_valid(a_pvalid),
    .queue_count(a_count), .bag_remaining(a_rem)
  );

  piece_bag_queue #(.NUM_SHAPES(4), .PREVIEW_DEPTH(6), .SEED(TB_SEED)) dut_b (
    .clk(clk), .reset(reset), .seed_load(seed_load), .seed_in(seed_in),
    .next_req(next_req), .piece_valid(b_valid), .piece_shape(b_shape),
    .piece_rot(b_rot), .preview_shapes(b_prev), .preview_valid(b_pvalid),
    .queue_count(b_count), .bag_remaining(b_rem)
  );

  typedef struct packed {
    logic        valid;
    logic [2:0]  shape;
    logic [1:0]  rot;
    logic [17:0] prev;
    logic        pvalid;
    logic [2:0]  count;
    logic [3:0]  rem;
  } outs_t;

  int checks = 0;
  int errors = 0;

  // Reference model: the queue is a list of {shape, rot} pieces, and the
  // bag is a list of "still available" flags per shape.
  int          m_sel;
  int          m_n;
  int          m_d;
  logic [15:0] m_lfsr;
  bit          m_avail [8];
  logic [4:0]  m_q [$];

  logic [4:0] popped [$];
  logic [4:0] seq_ref [$];
  bit         pattern [300];
  outs_t      obs, exp;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_restart(input logic [15:0] s);
    m_lfsr = s;
    m_q.delete();
    for (int i = 0; i < 8; i++) m_avail[i] = (i < m_n);
  endtask

  task automatic model_edge(input bit req, input bit sl, input logic [15:0] sd);
    int c, pick, left;
    bit do_pop, do_push;
    if (sl) begin
      model_restart((sd == 16'h0000) ? TB_SEED : sd);
      return;
    end
    c = int'(m_lfsr[2:0]);
    if (c >= m_n) c -= m_n;
    pick = -1;
    for (int k = 0; k < m_n; k++)
      if (pick < 0 && m_avail[(c + k) % m_n]) pick = (c + k) % m_n;
    do_pop  = req && (m_q.size() > 0);
    do_push = (m_q.size() - int'(do_pop)) < m_d;
    if (do_pop) void'(m_q.pop_front());
    if (do_push && pick >= 0) begin
      m_q.push_back({3'(pick), m_lfsr[4:3]});
      m_avail[pick] = 1'b0;
      left = 0;
      for (int k = 0; k < m_n; k++) left += int'(m_avail[k]);
      if (left == 0) for (int k = 0; k < m_n; k++) m_avail[k] = 1'b1;
    end
    m_lfsr = lfsr_step(m_lfsr);
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    int    left;
    o = '0;
    o.valid = (m_q.size() > 0);
    if (o.valid) begin
      o.shape = m_q[0][4:2];
      o.rot   = m_q[0][1:0];
    end
    for (int i = 0; i < m_d - 1; i++)
      if (i + 1 < m_q.size()) o.prev[3*i +: 3] = m_q[i+1][4:2];
    o.pvalid = (m_q.size() == m_d);
    o.count  = 3'(m_q.size());
    left = 0;
    for (int k = 0; k < m_n; k++) left += int'(m_avail[k]);
    o.rem = 4'(left);
    return o;
  endfunction

  function automatic outs_t dut_outs();
    outs_t o;
    if (m_sel == 0) begin
      o = '{a_valid, a_shape, a_rot, 18'(a_prev), a_pvalid, a_count, a_rem};
    end else begin
      o = '{b_valid, b_shape, b_rot, b_prev, b_pvalid, b_count, b_rem};
    end
    return o;
  endfunction

  // One clock: drive inputs, take the edge, update the model, then sample
  // 1 ns after the edge.
  task automatic cycle(input bit req, input bit sl, input logic [15:0] sd);
    next_req  = req;
    seed_load = sl;
    seed_in   = sd;
    @(posedge clk);
    #1;
    model_edge(req, sl, sd);
    next_req  = 1'b0;
    seed_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_restart(TB_SEED);
  endtask

  // Drive the shared random next_req pattern on dut_a and record popped
  // pieces.
  task automatic run_seq(input int npieces, input string name);
    bit r;
    popped.delete();
    for (int k = 0; k < 300 && popped.size() < npieces; k++) begin
      r = pattern[k];
      if (r && a_valid) popped.push_back({a_shape, a_rot});
      cycle(r, 1'b0, 16'h0);
      obs = dut_outs(); exp = model_outs(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, k, obs, exp);
      end
    end
    checks++;
    if (popped.size() < npieces) begin
      errors++;
      $display("FAIL %s budget: got %0d pieces expected %0d", name, popped.size(), npieces);
    end
  endtask

  task automatic test_reset();
    outs_t rst_a;
    rst_a = '{1'b0, 3'd0, 2'd0, 18'd0, 1'b0, 3'd0, 4'd7};
    reset = 1'b1; seed_load = 1'b0; next_req = 1'b0; seed_in = 16'h0;
    #3;
    m_sel = 0;
    for (int k = 0; k < 3; k++) begin
      obs = dut_outs(); checks++;
      if (obs !== rst_a) begin
        errors++;
        $display("FAIL reset_values %0d: got %h expected %h", k, obs, rst_a);
      end
      checks++;
      if (b_rem !== 4'd4 || b_count !== 3'd0 || b_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_b: got rem=%0d cnt=%0d v=%0b expected 4 0 0", b_rem, b_count, b_valid);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fill();
    int e;
    m_sel = 0; m_n = 7; m_d = 4;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 16'h0);
      e = (k < 4) ? k : 4;
      obs = dut_outs(); exp = model_outs(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL fill_model edge %0d: got %h expected %h", k, obs, exp);
      end
      checks++;
      if (a_count !== 3'(e) || a_pvalid !== (k >= 4) || a_rem !== 4'(7 - e) || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL fill_counts edge %0d: got cnt=%0d pv=%0b rem=%0d v=%0b expected cnt=%0d pv=%0b rem=%0d v=1",
                 k, a_count, a_pvalid, a_rem, a_valid, e, (k >= 4), 7 - e);
      end
    end
  endtask

  task automatic test_pop_stream();
    int hits, bad;
    m_sel = 0; m_n = 7; m_d = 4;
    do_reset();
    popped.delete();
    for (int k = 0; k < 200 && popped.size() < 70; k++) begin
      if (a_valid) popped.push_back({a_shape, a_rot});
      cycle(1'b1, 1'b0, 16'h0);
      obs = dut_outs(); exp = model_outs(); checks++;
      if (obs !== exp || a_valid !== 1'b1) begin
        errors++;
        $display("FAIL pop_stream cycle %0d: got %h expected %h", k, obs, exp);
      end
    end
    checks++;
    if (popped.size() != 70) begin
      errors++;
      $display("FAIL pop_stream budget: got %0d pieces expected 70", popped.size());
    end
    for (int g = 0; g < popped.size() / 7; g++) begin
      for (int c = 0; c < 7; c++) begin
        hits = 0;
        for (int j = 0; j < 7; j++) if (popped[g*7+j][4:2] == 3'(c)) hits++;
        checks++;
        if (hits != 1) begin
          errors++;
          $display("FAIL bag_group %0d code %0d: got %0d occurrences expected 1", g, c, hits);
        end
      end
    end
    bad = 0;
    foreach (popped[i]) if (popped[i][4:2] >= 3'd7) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL code_range: got %0d illegal codes expected 0", bad);
    end
  endtask

  task automatic test_seed_zero();
    int diff;
    m_sel = 0; m_n = 7; m_d = 4;
    do_reset();
    run_seq(20, "seed_reset_run");
    seq_ref = popped;
    cycle(1'b0, 1'b1, 16'h0000);
    run_seq(20, "seed_zero_run");
    diff = 0;
    for (int i = 0; i < 20; i++) if (popped[i] !== seq_ref[i]) diff++;
    checks++;
    if (diff != 0) begin
      errors++;
      $display("FAIL seed_zero_equiv: got %0d differing pieces expected 0", diff);
    end
  endtask

  task automatic test_seed_reproducible();
    int diff;
    m_sel = 0; m_n = 7; m_d = 4;
    cycle(1'b0, 1'b1, 16'h1234);
    run_seq(20, "seed1234_a");
    seq_ref = popped;
    for (int k = 0; k < 5; k++) cycle(1'($urandom_range(0, 1)), 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 16'h1234);
    run_seq(20, "seed1234_b");
    diff = 0;
    for (int i = 0; i < 20; i++) if (popped[i] !== seq_ref[i]) diff++;
    checks++;
    if (diff != 0) begin
      errors++;
      $display("FAIL seed_repeat: got %0d differing pieces expected 0", diff);
    end
    cycle(1'b0, 1'b1, 16'h4321);
    run_seq(7, "seed4321");
    diff = 0;
    for (int i = 0; i < 7; i++) if (popped[i] !== seq_ref[i]) diff++;
    checks++;
    if (diff == 0) begin
      errors++;
      $display("FAIL seed_differs: got 0 differing pieces expected at least 1");
    end
  endtask

  task automatic test_req_empty();
    m_sel = 0; m_n = 7; m_d = 4;
    do_reset();
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h5A5A);
    obs = dut_outs(); exp = model_outs(); checks++;
    if (obs !== exp || a_count !== 3'd0 || a_rem !== 4'd7 || a_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_with_req: got %h expected %h", obs, exp);
    end
    cycle(1'b1, 1'b0, 16'h0);
    obs = dut_outs(); exp = model_outs(); checks++;
    if (obs !== exp || a_count !== 3'd1 || a_valid !== 1'b1) begin
      errors++;
      $display("FAIL req_on_empty: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    outs_t rst_a;
    rst_a = '{1'b0, 3'd0, 2'd0, 18'd0, 1'b0, 3'd0, 4'd7};
    m_sel = 0; m_n = 7; m_d = 4;
    do_reset();
    cycle(1'b0, 1'b0, 16'h0);
    cycle(1'b0, 1'b0, 16'h0);
    checks++;
    if (a_count !== 3'd2) begin
      errors++;
      $display("FAIL async_setup: got cnt=%0d expected 2", a_count);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = dut_outs(); checks++;
    if (obs !== rst_a) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h expected %h", obs, rst_a);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_restart(TB_SEED);
    cycle(1'b0, 1'b0, 16'h0);
    obs = dut_outs(); exp = model_outs(); checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL async_recover: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_small_build();
    int hits, e;
    m_sel = 1; m_n = 4; m_d = 7;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, 1'b0, 16'h0);
      e = (k < 7) ? k : 7;
      obs = dut_outs(); exp = model_outs(); checks++;
      if (obs !== exp || b_count !== 3'(e) || b_pvalid !== (k >= 7)) begin
        errors++;
        $display("FAIL small_fill edge %0d: got %h expected %h", k, obs, exp);
      end
    end
    popped.delete();
    for (int k = 0; k < 100 && popped.size() < 24; k++) begin
      if (b_valid) popped.push_back({b_shape, b_rot});
      cycle(1'b1, 1'b0, 16'h0);
      obs = dut_outs(); exp = model_outs(); checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL small_pop cycle %0d: got %h expected %h", k, obs, exp);
      end
    end
    checks++;
    if (popped.size() != 24) begin
      errors++;
      $display("FAIL small_budget: got %0d pieces expected 24", popped.size());
    end
    for (int g = 0; g < popped.size() / 4; g++) begin
      for (int c = 0; c < 4; c++) begin
        hits = 0;
        for (int j = 0; j < 4; j++) if (popped[g*4+j][4:2] == 3'(c)) hits++;
        checks++;
        if (hits != 1) begin
          errors++;
          $display("FAIL small_bag group %0d code %0d: got %0d expected 1", g, c, hits);
        end
      end
    end
    m_sel = 0; m_n = 7; m_d = 4;
  endtask

  initial begin
    m_sel = 0; m_n = 7; m_d = 4;
    for (int i = 0; i < 300; i++) pattern[i] = ($urandom_range(0, 3) != 0);
    model_restart(TB_SEED);
    test_reset();
    test_fill();
    test_pop_stream();
    test_seed_zero();
    test_seed_reproducible();
    test_req_empty();
    test_async_reset();
    test_small_build();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/piece_bag_queue.md
# piece_bag_queue

Parametrised tetromino source for the game core: a free-running 16-bit LFSR drives a "bag" randomiser that deals every shape exactly once per bag, and a small FIFO holds the current piece plus a preview window. The spawn logic pops the head piece through a valid/request handshake, and the preview outputs feed the next-piece display. Seed is loadable at run time for reproducible games.

## Interface
- NUM_SHAPES, 7, shapes per bag; legal 4..8; shape codes 0..NUM_SHAPES-1
- PREVIEW_DEPTH, 3, number of preview entries; legal 1..6; queue depth D = PREVIEW_DEPTH+1
- SEED, 16'hACE1, LFSR reset value and substitute for a zero seed
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- seed_load  in  1  synchronous restart with seed_in
- seed_in  in  16  new LFSR seed
- next_req  in  1  pop head piece (honoured only when piece_valid=1)
- piece_valid  out  1  head entry present
- piece_shape  out  3  head shape code
- piece_rot  out  2  head rotation (0/90/180/270)
- preview_shapes  out  3*PREVIEW_DEPTH  entry i in bits [3i+2:3i] = queue slot i+1; 0 when slot empty
- preview_valid  out  1  queue full (all preview slots valid)
- queue_count  out  3  occupied slots, 0..D
- bag_remaining  out  4  shapes not yet dealt from current bag

## Operation
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400), shifts right every cycle unconditionally; never zero.
- Bag mask: NUM_SHAPES bits, 1 = not yet dealt. Reset/seed_load set all ones.
- Pick (combinational): c = lfsr[2:0]; if c >= NUM_SHAPES, c = c - NUM_SHAPES. Chosen shape = first set mask bit at index >= c, scanning upward with wrap to 0. Rotation = lfsr[4:3].
- Push: every cycle where (queue_count - pop) < D, write {shape, rot} at tail, clear chosen mask bit. If that clears the last bit, mask reloads to all ones the same edge (bag_remaining goes 1 -> NUM_SHAPES).
- Pop: next_req && piece_valid; head advances, slots shift toward head. next_req with piece_valid=0 ignored, no side effect.
- Simultaneous push and pop: both occur; count unchanged.
- seed_load: next edge loads LFSR with seed_in (SEED if seed_in==0), empties queue, refills mask; any same-cycle pop/push discarded. seed_load has priority over everything except reset.
- States: FILL (count < D) and FULL (count == D); pure function of count, no separate FSM register required, but FULL->FILL only via pop, FILL->FULL only via push.
- Arithmetic: queue_count and bag_remaining zero-extended; outputs for empty slots forced to 0.

## Timing
- Reset values: lfsr=SEED, mask all ones, queue_count=0, piece_valid=0, piece_shape=0, piece_rot=0, preview_shapes=0, preview_valid=0, bag_remaining=NUM_SHAPES.
- After reset deassert (or seed_load edge): piece_valid rises after first clk edge; preview_valid after D edges.
- Head outputs driven from registered queue storage: popped piece replaced on the edge that accepts next_req; new head visible immediately after that edge.
- Sustained next_req every cycle from FULL: piece_valid stays 1, count stays D, one new piece dealt per cycle.
- Sequence is a function of seed and pop timing (LFSR free-runs); identical seed + identical next_req pattern gives identical sequence.
- Async reset mid-operation: all state returns to reset values immediately, independent of clk.

## Test plan
- Reset, no pops, 10 cycles -> piece_valid=1 after edge 1, queue_count 1,2,3,4 then holds 4, preview_valid=1 from edge 4, bag_remaining 7->3.
- Reset, pop every cycle for 70 pieces -> every aligned group of 7 dealt pieces (counting from first) contains codes 0..6 exactly once; no code 7 ever; piece_valid never drops after edge 1.
- seed_load with seed_in=16'h0000 vs reset with SEED, same pop pattern -> identical 20-piece shape/rot sequence.
- Two runs seed_in=16'h1234, same pop pattern -> identical sequences; seed_in=16'h4321 -> sequence differs within first 7 pieces.
- next_req held high while queue empty (cycle of seed_load) -> no pop, queue_count=1 next cycle; seed_load and next_req same cycle -> queue_count=0 then refill, mask all ones.
- Assert reset asynchronously mid-fill (queue_count=2) and between clock edges -> outputs immediately at reset values; NUM_SHAPES=4, PREVIEW_DEPTH=6 build -> D=7, bags of 4 codes 0..3, preview_valid after 7 edges.
